// File: rtl/hex_dump_sched_pkg.sv
// hex_dump_pkg: shared types and ASCII constants for the hex dump scheduler.
//   state_t  - scheduler FSM encoding. ID/COLON exist only when
//              HEX_DUMP_SCHED_ID_EN is defined.
//   ASC_*    - byte constants used when building an output line.
package hex_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef HEX_DUMP_SCHED_ID_EN
    S_ID,
    S_COLON,
`endif
    S_HEX,
    S_CR,
    S_LF
  } state_t;

  localparam logic [7:0] ASC_CR      = 8'h0D;
  localparam logic [7:0] ASC_LF      = 8'h0A;
  localparam logic [7:0] ASC_COLON   = 8'h3A;
  localparam logic [7:0] ASC_ZERO    = 8'h30;
  localparam logic [7:0] ASC_LOWER_A = 8'h61;

endpackage

// File: rtl/hex_dump_sched_if.sv
// hex_dump_sched_if: requester side and byte-sink side of the scheduler.
//   req_valid/req_data/req_ready - per-requester word handshake
//                                  (requester i at [i*DATA_WIDTH +: DATA_WIDTH])
//   out_valid/out_data/out_ready - ASCII byte stream
//   busy                         - scheduler not in IDLE
// master: the scheduler. slave: the requesters plus the byte sink.
interface hex_dump_sched_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          out_valid;
  logic [7:0]                    out_data;
  logic                          out_ready;
  logic                          busy;

  modport master (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, busy
  );

  modport slave (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/hex_dump_sched_nib2asc.sv
// hex_dump_nib2asc: 4-bit nibble to lowercase hex ASCII.
//   nib in  4  value 0..15
//   asc out 8  '0'..'9' or 'a'..'f'
module hex_dump_nib2asc
  import hex_dump_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] asc
);
  always_comb begin
    if (nib < 4'd10) asc = ASC_ZERO + {4'h0, nib};
    else             asc = ASC_LOWER_A + {4'h0, nib} - 8'd10;
  end
endmodule

// File: rtl/hex_dump_sched_rr_arb.sv
// hex_dump_rr_arb: combinational round-robin pick.
//   req     in  NUM_REQ  request vector
//   ptr     in  PW       highest-priority index this round
//   gnt     out NUM_REQ  one-hot grant
//   gnt_idx out PW       index of the granted requester
//   any     out 1        some request is set
module hex_dump_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int PW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      gnt_idx,
  output logic               any
);
  // Walk upward from ptr with wrap; the first set request wins.
  always_comb begin
    int c;
    c       = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[c]) begin
        any     = 1'b1;
        gnt[c]  = 1'b1;
        gnt_idx = PW'(c);
      end
    end
  end
endmodule

// File: rtl/hex_dump_sched.sv
// hex_dump_sched: round-robin scheduler sharing one nibble-to-ASCII converter
// between NUM_REQ word sources. Each accepted word is emitted MSB nibble first
// as lowercase hex, then CR LF.
//   clk      in  clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   bus      master modport of hex_dump_sched_if (requests, byte stream, busy)
// Optional build macro HEX_DUMP_SCHED_ID_EN prefixes each line with the
// requester index digit and a colon.
module hex_dump_sched
  import hex_dump_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  hex_dump_sched_if.master bus
);
  localparam int N  = DATA_WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                state, state_nxt;
  logic [PW-1:0]         ptr, gnt_idx;
  logic [NUM_REQ-1:0]    gnt, req_ready_q;
  logic                  any;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] shadow;
  logic [3:0]            nib;
  logic [7:0]            nib_asc;
  logic                  out_valid;
  logic [7:0]            out_data;
  logic                  hs;
`ifdef HEX_DUMP_SCHED_ID_EN
  logic [PW-1:0]         gidx_q;
`endif

  hex_dump_rr_arb #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Single shared converter; its input is the current shadow nibble, or the
  // granted index while the ID prefix is being sent.
  hex_dump_nib2asc u_nib (
    .nib (nib),
    .asc (nib_asc)
  );

  assign hs = out_valid && bus.out_ready;

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_data  = 8'h00;
    nib       = 4'(shadow >> {idx, 2'b00});
    unique case (state)
      S_IDLE: if (any) state_nxt = S_LOAD;
`ifdef HEX_DUMP_SCHED_ID_EN
      S_LOAD: state_nxt = S_ID;
      S_ID: begin
        nib       = 4'(gidx_q);
        out_valid = 1'b1;
        out_data  = nib_asc;
        if (hs) state_nxt = S_COLON;
      end
      S_COLON: begin
        out_valid = 1'b1;
        out_data  = ASC_COLON;
        if (hs) state_nxt = S_HEX;
      end
`else
      S_LOAD: state_nxt = S_HEX;
`endif
      S_HEX: begin
        out_valid = 1'b1;
        out_data  = nib_asc;
        if (hs && idx == '0) state_nxt = S_CR;
      end
      S_CR: begin
        out_valid = 1'b1;
        out_data  = ASC_CR;
        if (hs) state_nxt = S_LF;
      end
      S_LF: begin
        out_valid = 1'b1;
        out_data  = ASC_LF;
        if (hs) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      idx         <= '0;
      shadow      <= '0;
      req_ready_q <= '0;
`ifdef HEX_DUMP_SCHED_ID_EN
      gidx_q      <= '0;
`endif
    end else begin
      state       <= state_nxt;
      req_ready_q <= '0;
      if (state == S_IDLE && any) begin
        req_ready_q <= gnt;
        shadow      <= DATA_WIDTH'(bus.req_data >> (int'(gnt_idx) * DATA_WIDTH));
        ptr         <= PW'((int'(gnt_idx) + 1) % NUM_REQ);
`ifdef HEX_DUMP_SCHED_ID_EN
        gidx_q      <= gnt_idx;
`endif
      end
      if (state == S_LOAD)
        idx <= IW'(N - 1);
      else if (state == S_HEX && hs && idx != '0)
        idx <= idx - IW'(1);
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_hex_dump_sched.sv
// Directed bench for hex_dump_sched: a NUM_REQ=2 instance for line content,
// backpressure, fairness and mid-line reset, plus a NUM_REQ=4 instance for
// pointer wrap. Builds with or without HEX_DUMP_SCHED_ID_EN.
module tb_hex_dump_sched;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hex_dump_sched_if #(.NUM_REQ(2), .DATA_WIDTH(32)) b2 ();
  hex_dump_sched_if #(.NUM_REQ(4), .DATA_WIDTH(32)) b4 ();

  hex_dump_sched #(.NUM_REQ(2), .DATA_WIDTH(32)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .bus(b2));
  hex_dump_sched #(.NUM_REQ(4), .DATA_WIDTH(32)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .bus(b4));

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_b [0:15];
  int exp_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    exp_b[exp_n] = b;
    exp_n++;
  endtask

  function automatic logic [7:0] hx(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
  endfunction

  task automatic prefix(input int id);
`ifdef HEX_DUMP_SCHED_ID_EN
    push(hx(4'(id)));
    push(8'h3A);
`else
    if (id < 0) push(8'hFF);
`endif
  endtask

  task automatic build_line(input logic [31:0] w, input int id);
    exp_n = 0;
    prefix(id);
    for (int i = 7; i >= 0; i--) push(hx(4'(w >> (4 * i))));
    push(8'h0D);
    push(8'h0A);
  endtask

  task automatic wait_grant(input logic [1:0] exp);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (b2.req_ready == 2'b00 && n < 20);
    chk("grant", 32'(b2.req_ready), 32'(exp));
    chk("load_no_valid", 32'(b2.out_valid), 32'd0);
    chk("load_busy", 32'(b2.busy), 32'd1);
  endtask

  task automatic run_line(input bit toggle);
    logic [7:0] got [0:15];
    int got_n = 0;
    int cyc = 0;
    int gaps = 0;
    bit stall = 1'b0;
    logic [7:0] stall_d = 8'h00;
    b2.out_ready = 1'b1;
    while (got_n < exp_n && cyc < 200) begin
      @(negedge clk);
      if (toggle) b2.out_ready = (cyc % 2 == 0);
      if (cyc == 0) chk("first_byte_valid", 32'(b2.out_valid), 32'd1);
      if (stall) begin
        chk("stall_valid", 32'(b2.out_valid), 32'd1);
        chk("stall_data", 32'(b2.out_data), 32'(stall_d));
      end
      if (b2.out_valid && b2.out_ready) begin
        got[got_n] = b2.out_data;
        got_n++;
        stall = 1'b0;
      end else if (b2.out_valid) begin
        stall = 1'b1;
        stall_d = b2.out_data;
      end else begin
        gaps++;
      end
      cyc++;
    end
    chk("line_len", 32'(got_n), 32'(exp_n));
    chk("line_gaps", 32'(gaps), 32'd0);
    for (int k = 0; k < exp_n && k < got_n; k++)
      chk($sformatf("byte%0d", k), 32'(got[k]), 32'(exp_b[k]));
    b2.out_ready = 1'b1;
    @(negedge clk);
    chk("end_busy", 32'(b2.busy), 32'd0);
    chk("end_valid", 32'(b2.out_valid), 32'd0);
  endtask

  task automatic grant4(input logic [3:0] rv, input logic [3:0] exp);
    int n = 0;
    b4.req_valid = rv;
    do begin
      @(negedge clk);
      n++;
    end while (b4.req_ready == 4'b0 && n < 20);
    chk("wrap_grant", 32'(b4.req_ready), 32'(exp));
    b4.req_valid = 4'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (b4.busy && n < 40);
    chk("wrap_drain", 32'(b4.busy), 32'd0);
  endtask

  initial begin
    b2.req_valid = '0;
    b2.req_data  = '0;
    b2.out_ready = 1'b1;
    b4.req_valid = '0;
    b4.req_data  = '0;
    b4.out_ready = 1'b1;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(b2.req_ready), 32'd0);
    chk("rst_out_valid", 32'(b2.out_valid), 32'd0);
    chk("rst_out_data", 32'(b2.out_data), 32'd0);
    chk("rst_busy", 32'(b2.busy), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // single word, sink always ready
    exp_n = 0;
    prefix(0);
    push(8'h64); push(8'h65); push(8'h61); push(8'h64);
    push(8'h62); push(8'h65); push(8'h65); push(8'h66);
    push(8'h0D); push(8'h0A);
    b2.req_data  = {32'h0, 32'hDEADBEEF};
    b2.req_valid = 2'b01;
    wait_grant(2'b01);
    b2.req_valid = 2'b00;
    run_line(1'b0);

    // same word, sink ready toggling every cycle
    b2.req_valid = 2'b01;
    wait_grant(2'b01);
    b2.req_valid = 2'b00;
    run_line(1'b1);

    // fresh pointer, then both requesters held high for 8 lines
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    b2.req_data  = {32'h0000000F, 32'h00000001};
    b2.req_valid = 2'b11;
    for (int l = 0; l < 8; l++) begin
      build_line((l % 2 == 0) ? 32'h1 : 32'hF, l % 2);
      wait_grant((l % 2 == 0) ? 2'b01 : 2'b10);
      run_line(1'b0);
    end
    b2.req_valid = 2'b00;

    // requester 1 alone
    b2.req_data  = {32'h0000CAFE, 32'h0};
    b2.req_valid = 2'b10;
    build_line(32'h0000CAFE, 1);
    wait_grant(2'b10);
    b2.req_valid = 2'b00;
    run_line(1'b0);

    // reset in the middle of a line
    b2.req_data  = {32'h0, 32'h12345678};
    b2.req_valid = 2'b01;
    wait_grant(2'b01);
    b2.req_valid = 2'b00;
    build_line(32'h12345678, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_valid", 32'(b2.out_valid), 32'd1);
      chk($sformatf("mid_byte%0d", k), 32'(b2.out_data), 32'(exp_b[k]));
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(b2.out_valid), 32'd0);
    chk("mrst_out_data", 32'(b2.out_data), 32'd0);
    chk("mrst_busy", 32'(b2.busy), 32'd0);
    chk("mrst_req_ready", 32'(b2.req_ready), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 32'(b2.out_valid), 32'd0);
    exp_n = 0;
    prefix(0);
    push(8'h61);
    for (int k = 0; k < 7; k++) push(8'h30);
    push(8'h0D); push(8'h0A);
    b2.req_data  = {32'h0, 32'hA0000000};
    b2.req_valid = 2'b01;
    wait_grant(2'b01);
    b2.req_valid = 2'b00;
    run_line(1'b0);

    // pointer wrap on the 4-requester instance
    grant4(4'b0100, 4'b0100);
    grant4(4'b0010, 4'b0010);
    grant4(4'b1010, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
